// File: rtl/upct_update_arbiter.sv
// Two-requester round-robin front end for the UPCT update port.
// Each requester owns a 2-entry {PC, tag} FIFO; one head is granted per cycle and tracked for its index response.

module upct_req_fifo (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        i_flush,
   input  logic        i_valid,
   input  logic [31:0] i_pc,
   input  logic [2:0]  i_tag,
   input  logic        i_deq,
   output logic        o_ready,
   output logic        o_nonempty,
   output logic [31:0] o_head_pc,
   output logic [2:0]  o_head_tag
);
   logic [1:0][31:0] r_pc;
   logic [1:0][2:0]  r_tag;
   logic             r_wr;
   logic             r_rd;
   logic [1:0]       r_cnt;
   logic             w_enq;
   logic             w_deq;

   // Ready looks only at the registered count: a same-cycle dequeue does not open a slot.
   assign o_ready    = !i_flush && (r_cnt < 2'd2);
   assign o_nonempty = (r_cnt != 2'd0);
   assign o_head_pc  = r_pc[r_rd];
   assign o_head_tag = r_tag[r_rd];
   assign w_enq      = i_valid && o_ready;
   assign w_deq      = i_deq && o_nonempty && !i_flush;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_pc  <= '0;
         r_tag <= '0;
         r_wr  <= 1'b0;
         r_rd  <= 1'b0;
         r_cnt <= 2'd0;
      end else if (i_flush) begin
         r_wr  <= 1'b0;
         r_rd  <= 1'b0;
         r_cnt <= 2'd0;
      end else begin
         if (w_enq) begin
            r_pc[r_wr]  <= i_pc;
            r_tag[r_wr] <= i_tag;
            r_wr        <= ~r_wr;
         end
         if (w_deq)
            r_rd <= ~r_rd;
         case ({w_enq, w_deq})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end
endmodule

module upct_update_arbiter #(
   parameter int LOG_UPCT_ENTRIES = 4
) (
   input  logic                        CLK,
   input  logic                        nRST,
   input  logic                        req0_valid,
   input  logic [31:0]                 req0_start_full_PC,
   input  logic [2:0]                  req0_tag,
   output logic                        req0_ready,
   input  logic                        req1_valid,
   input  logic [31:0]                 req1_start_full_PC,
   input  logic [2:0]                  req1_tag,
   output logic                        req1_ready,
   input  logic                        flush,
   output logic                        update0_valid,
   output logic [31:0]                 update0_start_full_PC,
   input  logic [LOG_UPCT_ENTRIES-1:0] update1_upct_index,
   output logic                        resp_valid,
   output logic                        resp_requester,
   output logic [2:0]                  resp_tag,
   output logic [LOG_UPCT_ENTRIES-1:0] resp_upct_index
);
   localparam int NUM_REQ = 2;

   logic [NUM_REQ-1:0]        w_vld;
   logic [NUM_REQ-1:0][31:0]  w_pc;
   logic [NUM_REQ-1:0][2:0]   w_tag;
   logic [NUM_REQ-1:0]        w_rdy;
   logic [NUM_REQ-1:0]        w_ne;
   logic [NUM_REQ-1:0]        w_deq;
   logic [NUM_REQ-1:0][31:0]  w_head_pc;
   logic [NUM_REQ-1:0][2:0]   w_head_tag;
   logic                      w_both;
   logic                      w_gnt_vld;
   logic                      w_gnt_idx;

   logic                      r_ptr;
   logic                      r_if_vld;
   logic                      r_if_req;
   logic [2:0]                r_if_tag;

   assign w_vld = {req1_valid, req0_valid};
   assign w_pc  = {req1_start_full_PC, req0_start_full_PC};
   assign w_tag = {req1_tag, req0_tag};

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
      assign w_deq[g] = w_gnt_vld && (w_gnt_idx == 1'(g));
      upct_req_fifo u_fifo (
         .CLK        (CLK),
         .nRST       (nRST),
         .i_flush    (flush),
         .i_valid    (w_vld[g]),
         .i_pc       (w_pc[g]),
         .i_tag      (w_tag[g]),
         .i_deq      (w_deq[g]),
         .o_ready    (w_rdy[g]),
         .o_nonempty (w_ne[g]),
         .o_head_pc  (w_head_pc[g]),
         .o_head_tag (w_head_tag[g])
      );
   end

   assign req0_ready = w_rdy[0];
   assign req1_ready = w_rdy[1];

   // Pointer only arbitrates under contention; a lone requester wins outright.
   assign w_both    = &w_ne;
   assign w_gnt_idx = w_both ? r_ptr : w_ne[1];
   assign w_gnt_vld = (|w_ne) && !flush;

   assign update0_valid         = w_gnt_vld;
   assign update0_start_full_PC = w_gnt_vld ? w_head_pc[w_gnt_idx] : 32'd0;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_ptr    <= 1'b0;
         r_if_vld <= 1'b0;
         r_if_req <= 1'b0;
         r_if_tag <= 3'd0;
      end else if (flush) begin
         r_ptr    <= 1'b0;
         r_if_vld <= 1'b0;
      end else begin
         r_if_vld <= w_gnt_vld;
         if (w_gnt_vld) begin
            r_if_req <= w_gnt_idx;
            r_if_tag <= w_head_tag[w_gnt_idx];
            if (w_both)
               r_ptr <= ~w_gnt_idx;
         end
      end
   end

   // The UPCT returns the index one cycle after update0; it is paired with the in-flight stage here.
   assign resp_valid      = r_if_vld && !flush;
   assign resp_requester  = r_if_req;
   assign resp_tag        = r_if_tag;
   assign resp_upct_index = update1_upct_index;
endmodule

// File: tb/tb_upct_update_arbiter.sv
// Self-checking bench: directed vector table, corner-case sequences, then random traffic vs. a queue-based model.
module tb_upct_update_arbiter;
   localparam int LW = 4;

   logic          CLK = 1'b0;
   logic          nRST = 1'b0;
   logic          req0_valid = 1'b0, req1_valid = 1'b0, flush = 1'b0;
   logic [31:0]   req0_start_full_PC = '0, req1_start_full_PC = '0;
   logic [2:0]    req0_tag = '0, req1_tag = '0;
   logic          req0_ready, req1_ready;
   logic          update0_valid;
   logic [31:0]   update0_start_full_PC;
   logic [LW-1:0] update1_upct_index = '0;
   logic          resp_valid, resp_requester;
   logic [2:0]    resp_tag;
   logic [LW-1:0] resp_upct_index;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   upct_update_arbiter #(.LOG_UPCT_ENTRIES(LW)) dut (
      .CLK(CLK), .nRST(nRST),
      .req0_valid(req0_valid), .req0_start_full_PC(req0_start_full_PC), .req0_tag(req0_tag), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_start_full_PC(req1_start_full_PC), .req1_tag(req1_tag), .req1_ready(req1_ready),
      .flush(flush), .update0_valid(update0_valid), .update0_start_full_PC(update0_start_full_PC),
      .update1_upct_index(update1_upct_index), .resp_valid(resp_valid), .resp_requester(resp_requester),
      .resp_tag(resp_tag), .resp_upct_index(resp_upct_index)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic v0, input logic [31:0] p0, input logic [2:0] t0,
                        input logic v1, input logic [31:0] p1, input logic [2:0] t1,
                        input logic fl, input logic [LW-1:0] ix);
      req0_valid = v0; req0_start_full_PC = p0; req0_tag = t0;
      req1_valid = v1; req1_start_full_PC = p1; req1_tag = t1;
      flush = fl; update1_upct_index = ix;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      nRST = 1'b0;
      #1;
      chk("rst_u0v", update0_valid, 0);
      chk("rst_rv", resp_valid, 0);
      chk("rst_rreq", resp_requester, 0);
      chk("rst_rtag", resp_tag, 0);
      chk("rst_rdy0", req0_ready, 1);
      chk("rst_rdy1", req1_ready, 1);
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   typedef struct {
      logic v0; logic [31:0] pc0; logic [2:0] tag0;
      logic v1; logic [31:0] pc1; logic [2:0] tag1;
      logic [LW-1:0] idx;
      logic e_u0v; logic [31:0] e_pc;
      logic e_rv; logic e_rreq; logic [2:0] e_rtag; logic [LW-1:0] e_ridx;
      logic e_rdy0; logic e_rdy1;
   } vec_t;
   vec_t tbl [10];

   typedef struct { logic [31:0] pc; logic [2:0] tag; } ent_t;
   ent_t q0[$], q1[$];
   int   m_ptr;
   bit   m_ifv, m_ifr;
   logic [2:0] m_ift;

   initial begin
      // Single request, then two-requester contention (grant order 0,1,0,1).
      tbl[0] = '{1, 32'h4000, 3, 0, 0, 0, 5, 0, 0,         0, 0, 0, 0, 1, 1};
      tbl[1] = '{0, 0, 0,        0, 0, 0, 5, 1, 32'h4000,  0, 0, 0, 0, 1, 1};
      tbl[2] = '{0, 0, 0,        0, 0, 0, 5, 0, 0,         1, 0, 3, 5, 1, 1};
      tbl[3] = '{1, 32'h100, 1,  1, 32'h200, 5, 0, 0, 0,   0, 0, 0, 0, 1, 1};
      tbl[4] = '{1, 32'h104, 2,  1, 32'h204, 6, 0, 1, 32'h100, 0, 0, 0, 0, 1, 1};
      tbl[5] = '{0, 0, 0,        0, 0, 0, 7, 1, 32'h200,   1, 0, 1, 7, 1, 0};
      tbl[6] = '{0, 0, 0,        0, 0, 0, 2, 1, 32'h104,   1, 1, 5, 2, 1, 1};
      tbl[7] = '{0, 0, 0,        0, 0, 0, 9, 1, 32'h204,   1, 0, 2, 9, 1, 1};
      tbl[8] = '{0, 0, 0,        0, 0, 0, 3, 0, 0,         1, 1, 6, 3, 1, 1};
      tbl[9] = '{0, 0, 0,        0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 1, 1};

      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         drive(tbl[i].v0, tbl[i].pc0, tbl[i].tag0, tbl[i].v1, tbl[i].pc1, tbl[i].tag1, 0, tbl[i].idx);
         #1;
         chk($sformatf("tbl%0d_u0v", i), update0_valid, tbl[i].e_u0v);
         chk($sformatf("tbl%0d_pc", i), update0_start_full_PC, tbl[i].e_pc);
         chk($sformatf("tbl%0d_rv", i), resp_valid, tbl[i].e_rv);
         if (tbl[i].e_rv) begin
            chk($sformatf("tbl%0d_rreq", i), resp_requester, tbl[i].e_rreq);
            chk($sformatf("tbl%0d_rtag", i), resp_tag, tbl[i].e_rtag);
            chk($sformatf("tbl%0d_ridx", i), resp_upct_index, tbl[i].e_ridx);
         end
         chk($sformatf("tbl%0d_rdy0", i), req0_ready, tbl[i].e_rdy0);
         chk($sformatf("tbl%0d_rdy1", i), req1_ready, tbl[i].e_rdy1);
      end

      // req1 held valid: ready drops once its FIFO is full, returns after a dequeue.
      do_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK);
         drive(1, 32'h1000 + c, 0, 1, 32'h2000 + c, 0, 0, 0);
         #1;
         chk($sformatf("hold%0d_rdy1", c), req1_ready, (c == 2) ? 0 : 1);
         if (c == 1) chk("hold_pc_a0", update0_start_full_PC, 32'h1000);
         if (c == 2) chk("hold_pc_b0", update0_start_full_PC, 32'h2000);
         if (c == 3) chk("hold_pc_a1", update0_start_full_PC, 32'h1001);
      end

      // Flush with both FIFOs occupied and an update in flight.
      do_reset();
      @(negedge CLK); drive(1, 32'h10, 1, 1, 32'h20, 2, 0, 0);
      @(negedge CLK); drive(1, 32'h11, 3, 1, 32'h21, 4, 0, 0);
      @(negedge CLK); drive(1, 32'h12, 5, 1, 32'h22, 6, 1, 0);
      #1;
      chk("fl_u0v", update0_valid, 0);
      chk("fl_rv", resp_valid, 0);
      chk("fl_rdy0", req0_ready, 0);
      chk("fl_rdy1", req1_ready, 0);
      @(negedge CLK); drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("flp_u0v", update0_valid, 0);
      chk("flp_rv", resp_valid, 0);
      chk("flp_rdy0", req0_ready, 1);
      chk("flp_rdy1", req1_ready, 1);
      @(negedge CLK); #1;
      chk("flp2_rv", resp_valid, 0);
      chk("flp2_u0v", update0_valid, 0);

      // Reset between grant and response; pointer must come back at 0.
      do_reset();
      @(negedge CLK); drive(1, 32'h30, 1, 1, 32'h40, 2, 0, 0);
      @(negedge CLK); drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("mr_u0v", update0_valid, 1);
      chk("mr_pc", update0_start_full_PC, 32'h30);
      #2 nRST = 1'b0;
      @(negedge CLK); nRST = 1'b1;
      #1;
      chk("mr_rv", resp_valid, 0);
      chk("mr_u0v2", update0_valid, 0);
      chk("mr_rreq", resp_requester, 0);
      chk("mr_rtag", resp_tag, 0);
      chk("mr_rdy0", req0_ready, 1);
      chk("mr_rdy1", req1_ready, 1);
      drive(1, 32'h50, 1, 1, 32'h60, 2, 0, 0);
      @(negedge CLK); drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("mr_rv2", resp_valid, 0);
      chk("mr_pc0wins", update0_start_full_PC, 32'h50);

      // Only req1 active: granted every time, pointer stays 0.
      do_reset();
      @(negedge CLK); drive(0, 0, 0, 1, 32'h70, 1, 0, 0);
      @(negedge CLK); drive(0, 0, 0, 1, 32'h71, 2, 0, 0);
      #1; chk("r1_pc0", update0_start_full_PC, 32'h70);
      @(negedge CLK); drive(0, 0, 0, 1, 32'h72, 3, 0, 4);
      #1; chk("r1_pc1", update0_start_full_PC, 32'h71);
      chk("r1_rreq1", resp_requester, 1); chk("r1_rtag1", resp_tag, 1); chk("r1_rv1", resp_valid, 1);
      @(negedge CLK); drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1; chk("r1_pc2", update0_start_full_PC, 32'h72); chk("r1_rtag2", resp_tag, 2);
      @(negedge CLK); drive(1, 32'h80, 7, 1, 32'h73, 4, 0, 0);
      #1; chk("r1_rtag3", resp_tag, 3); chk("r1_u0v", update0_valid, 0);
      @(negedge CLK); drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1; chk("r1_ptr0_pc", update0_start_full_PC, 32'h80);
      @(negedge CLK); #1;
      chk("r1_next_pc", update0_start_full_PC, 32'h73);
      chk("r1_next_rreq", resp_requester, 0);
      chk("r1_next_rtag", resp_tag, 7);

      // Random traffic against the queue model.
      do_reset();
      q0.delete(); q1.delete(); m_ptr = 0; m_ifv = 0; m_ifr = 0; m_ift = 0;
      for (int c = 0; c < 3000; c++) begin
         logic v0, v1, fl;
         logic [31:0] p0, p1;
         logic [2:0] t0, t1;
         logic [LW-1:0] ix;
         int gnt;
         logic e_rdy0, e_rdy1;
         logic [31:0] e_pc;
         logic [2:0] g_tag;
         v0 = ($urandom_range(0, 99) < 55);
         v1 = ($urandom_range(0, 99) < 55);
         fl = ($urandom_range(0, 99) < 4);
         p0 = $urandom; p1 = $urandom;
         t0 = 3'($urandom); t1 = 3'($urandom);
         ix = LW'($urandom);
         @(negedge CLK);
         drive(v0, p0, t0, v1, p1, t1, fl, ix);
         #1;
         e_rdy0 = !fl && (q0.size() < 2);
         e_rdy1 = !fl && (q1.size() < 2);
         gnt = -1;
         if (!fl) begin
            if (q0.size() > 0 && q1.size() > 0) gnt = m_ptr;
            else if (q0.size() > 0)             gnt = 0;
            else if (q1.size() > 0)             gnt = 1;
         end
         e_pc = 0; g_tag = 0;
         if (gnt == 0) begin e_pc = q0[0].pc; g_tag = q0[0].tag; end
         if (gnt == 1) begin e_pc = q1[0].pc; g_tag = q1[0].tag; end
         chk("rnd_rdy0", req0_ready, e_rdy0);
         chk("rnd_rdy1", req1_ready, e_rdy1);
         chk("rnd_u0v", update0_valid, gnt >= 0);
         chk("rnd_pc", update0_start_full_PC, e_pc);
         chk("rnd_rv", resp_valid, m_ifv && !fl);
         if (m_ifv && !fl) begin
            chk("rnd_rreq", resp_requester, m_ifr);
            chk("rnd_rtag", resp_tag, m_ift);
            chk("rnd_ridx", resp_upct_index, ix);
         end
         if (fl) begin
            q0.delete(); q1.delete(); m_ptr = 0; m_ifv = 0;
         end else begin
            if (gnt >= 0 && q0.size() > 0 && q1.size() > 0) m_ptr = 1 - gnt;
            if (gnt == 0) void'(q0.pop_front());
            if (gnt == 1) void'(q1.pop_front());
            if (v0 && e_rdy0) q0.push_back('{p0, t0});
            if (v1 && e_rdy1) q1.push_back('{p1, t1});
            m_ifv = (gnt >= 0);
            if (gnt >= 0) begin m_ifr = (gnt == 1); m_ift = g_tag; end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
